// File: rtl/dom_share_feeder_pkg.sv
// Shared types and constants for the DOM share feeder slice.
package dom_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHARE,
        HOLD
    } dom_state_e;

    localparam int unsigned NSHARES     = 3;
    localparam int unsigned RAND_PER_OP = 7;

    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2D5B;

endpackage

// File: rtl/dom_share_feeder_if.sv
// Operand offer channel (valid/ready plus unmasked operands) into the share feeder.
interface dom_share_feeder_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;

    modport master (output in_valid, output a_in, output b_in, input  in_ready);
    modport slave  (input  in_valid, input  a_in, input  b_in, output in_ready);
endinterface

// File: rtl/dom_share_feeder_lfsr_step.sv
// Combinational multi-step advance of a right-shift Galois LFSR.
module dom_lfsr_step #(
    parameter int unsigned          LFSR_W = 32,
    parameter int unsigned          STEPS  = 7,
    parameter logic [LFSR_W-1:0]    TAPS   = LFSR_W'(32'h8020_0003)
) (
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] nxt;

    always_comb begin
        nxt = state_i;
        for (int unsigned i = 0; i < STEPS; i++) begin
            nxt = {1'b0, nxt[LFSR_W-1:1]} ^ (nxt[0] ? TAPS : '0);
        end
        state_o = nxt;
    end

endmodule

// File: rtl/dom_share_feeder.sv
// Splits operands into 3 Boolean shares and supplies DOM gadget randomness for a 2-cycle gadget.
// Optional macro DOM_FEEDER_DBG_EN adds dbg_ref, the unmasked golden product of the op in flight.
module dom_share_feeder
    import dom_pkg::*;
#(
    parameter int unsigned       WIDTH  = 1,
    parameter int unsigned       LFSR_W = 32,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
    input  logic                clk,
    input  logic                rst,
    dom_share_feeder_if.slave   in_bus,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed_data,
    output logic [WIDTH-1:0]    a0,
    output logic [WIDTH-1:0]    a1,
    output logic [WIDTH-1:0]    a2,
    output logic [WIDTH-1:0]    b0,
    output logic [WIDTH-1:0]    b1,
    output logic [WIDTH-1:0]    b2,
    output logic [WIDTH-1:0]    z10,
    output logic [WIDTH-1:0]    z20,
    output logic [WIDTH-1:0]    z21,
`ifdef DOM_FEEDER_DBG_EN
    output logic [WIDTH-1:0]    dbg_ref,
`endif
    output logic                out_valid
);

    localparam int unsigned       NRAND = RAND_PER_OP * WIDTH;
    localparam logic [LFSR_W-1:0] TAPS  = LFSR_W'(LFSR_TAPS_32);

    if (NRAND > LFSR_W) begin : g_bad_width
        $error("dom_share_feeder: 7*WIDTH exceeds LFSR_W");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("dom_share_feeder: SEED must be non-zero");
    end

    dom_state_e state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
    logic [NSHARES-1:0][WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [2:0][WIDTH-1:0] z_q, z_d;
    logic [RAND_PER_OP-1:0][WIDTH-1:0] r;
    logic accept, load_op, clear_op;

    assign r                = lfsr_q[NRAND-1:0];
    assign in_bus.in_ready  = (state_q != SHARE);
    assign accept           = in_bus.in_valid & in_bus.in_ready;
    assign out_valid        = (state_q == HOLD);

    dom_lfsr_step #(
        .LFSR_W (LFSR_W),
        .STEPS  (NRAND),
        .TAPS   (TAPS)
    ) u_step (
        .state_i (lfsr_q),
        .state_o (lfsr_adv)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        z_d      = z_q;
        load_op  = 1'b0;
        clear_op = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHARE;
                    load_op = 1'b1;
                end
            end
            SHARE: state_d = HOLD;
            HOLD: begin
                if (accept) begin
                    state_d = SHARE;
                    load_op = 1'b1;
                end else begin
                    state_d  = IDLE;
                    clear_op = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_op) begin
            a_sh_d[1] = r[0];
            a_sh_d[2] = r[1];
            a_sh_d[0] = in_bus.a_in ^ r[0] ^ r[1];
            b_sh_d[1] = r[2];
            b_sh_d[2] = r[3];
            b_sh_d[0] = in_bus.b_in ^ r[2] ^ r[3];
            z_d[0]    = r[4];
            z_d[1]    = r[5];
            z_d[2]    = r[6];
        end else if (clear_op) begin
            a_sh_d = '0;
            b_sh_d = '0;
            z_d    = '0;
        end

        // Masks for an accepted op come from lfsr_q, so a same-cycle reseed may override the advance.
        if (seed_load) begin
            lfsr_d = (seed_data == '0) ? SEED : seed_data;
        end else if (accept) begin
            lfsr_d = lfsr_adv;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            z_q     <= z_d;
        end
    end

    assign {a2, a1, a0} = a_sh_q;
    assign {b2, b1, b0} = b_sh_q;
    assign {z21, z20, z10} = z_q;

`ifdef DOM_FEEDER_DBG_EN
    logic [WIDTH-1:0] dbg_q, dbg_d;

    always_comb begin
        dbg_d = dbg_q;
        if (load_op) begin
            dbg_d = in_bus.a_in & in_bus.b_in;
        end else if (clear_op) begin
            dbg_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign dbg_ref = dbg_q;
`endif

endmodule

// File: tb/tb_dom_share_feeder.sv
// Randomised and directed bench for dom_share_feeder against a behavioural share/gadget model.
module tb_dom_share_feeder;

    localparam int unsigned W    = 4;
    localparam int unsigned LW   = 32;
    localparam logic [31:0] SEED = 32'hACE1_2D5B;
    // Polynomial x^32 + x^22 + x^2 + x + 1 as a right-shift Galois feedback mask
    localparam logic [31:0] POLY_MASK = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;

    logic clk = 1'b0;
    logic rst;
    logic seed_load;
    logic [LW-1:0] seed_data;
    logic [W-1:0] a0, a1, a2, b0, b1, b2, z10, z20, z21;
    logic out_valid;
`ifdef DOM_FEEDER_DBG_EN
    logic [W-1:0] dbg_ref;
`endif

    always #5 clk = ~clk;

    dom_share_feeder_if #(.WIDTH(W)) bus ();

    dom_share_feeder #(
        .WIDTH  (W),
        .LFSR_W (LW),
        .SEED   (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (bus),
        .seed_load (seed_load),
        .seed_data (seed_data),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .z10       (z10),
        .z20       (z20),
        .z21       (z21),
`ifdef DOM_FEEDER_DBG_EN
        .dbg_ref   (dbg_ref),
`endif
        .out_valid (out_valid)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Reference model: phase 0 = idle, 1 = shares just issued, 2 = gadget result cycle
    logic [31:0]  m_lfsr;
    int           m_phase;
    logic [W-1:0] e_sh [9];
    logic [W-1:0] m_a, m_b, e_dbg;
    logic [7*W-1:0] prev_r;
    bit           have_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int unsigned n);
        logic [31:0] v;
        v = s;
        for (int unsigned i = 0; i < n; i++) begin
            v = (v >> 1) ^ ((v & 32'd1) != 0 ? POLY_MASK : 32'd0);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] dom_and(input logic [W-1:0] x0, x1, x2, y0, y1, y2, r10, r20, r21);
        logic [W-1:0] c0, c1, c2;
        c0 = (x0 & y0) ^ ((x0 & y1) ^ r10) ^ ((x0 & y2) ^ r20);
        c1 = (x1 & y1) ^ ((x1 & y0) ^ r10) ^ ((x1 & y2) ^ r21);
        c2 = (x2 & y2) ^ ((x2 & y0) ^ r20) ^ ((x2 & y1) ^ r21);
        return c0 ^ c1 ^ c2;
    endfunction

    task automatic model_reset();
        m_lfsr    = SEED;
        m_phase   = 0;
        e_dbg     = '0;
        have_prev = 1'b0;
        for (int k = 0; k < 9; k++) e_sh[k] = '0;
    endtask

    task automatic check_outputs();
        logic [W-1:0] o [9];
        o = '{a0, a1, a2, b0, b1, b2, z10, z20, z21};
        for (int k = 0; k < 9; k++) chk($sformatf("share%0d", k), 64'(o[k]), 64'(e_sh[k]));
        chk("in_ready", 64'(bus.in_ready), 64'(m_phase != 1));
        chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
        if (m_phase != 0) begin
            chk("recomb_a", 64'(a0 ^ a1 ^ a2), 64'(m_a));
            chk("recomb_b", 64'(b0 ^ b1 ^ b2), 64'(m_b));
        end
        if (m_phase == 2)
            chk("gadget_c", 64'(dom_and(a0, a1, a2, b0, b1, b2, z10, z20, z21)), 64'(m_a & m_b));
`ifdef DOM_FEEDER_DBG_EN
        chk("dbg_ref", 64'(dbg_ref), 64'(e_dbg));
`endif
    endtask

    task automatic tick();
        bit acc;
        logic [7*W-1:0] r, obs_r;
        acc = bus.in_valid && (m_phase != 1);
        @(posedge clk);
        if (acc) begin
            r       = m_lfsr[7*W-1:0];
            e_sh[1] = r[W-1:0];
            e_sh[2] = r[2*W-1:W];
            e_sh[4] = r[3*W-1:2*W];
            e_sh[5] = r[4*W-1:3*W];
            e_sh[6] = r[5*W-1:4*W];
            e_sh[7] = r[6*W-1:5*W];
            e_sh[8] = r[7*W-1:6*W];
            m_a     = bus.a_in;
            m_b     = bus.b_in;
            e_sh[0] = m_a ^ e_sh[1] ^ e_sh[2];
            e_sh[3] = m_b ^ e_sh[4] ^ e_sh[5];
            e_dbg   = m_a & m_b;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
            e_dbg   = '0;
            for (int k = 0; k < 9; k++) e_sh[k] = '0;
        end
        if (seed_load) begin
            m_lfsr = (seed_data == 0) ? SEED : seed_data;
        end else if (acc) begin
            m_lfsr = lfsr_adv(m_lfsr, 7 * W);
        end
        #1;
        check_outputs();
        if (acc) begin
            obs_r = {z21, z20, z10, b2, b1, a2, a1};
            if (have_prev) chk("mask_fresh", 64'(obs_r != prev_r), 64'd1);
            prev_r    = obs_r;
            have_prev = 1'b1;
        end
        if (seed_load) have_prev = 1'b0;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        seed_load    = 1'b0;
        seed_data    = '0;
        model_reset();

        // Reset state, then release
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        check_outputs();
        tick();

        // Single op, all lanes 1
        op('1, '1);
        repeat (3) tick();

        // Back-to-back with in_valid held; operands change every cycle
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.a_in = W'($urandom);
            bus.b_in = W'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (2) tick();

        // Golden-product ordering: a=1,b=0 then a=1,b=1
        op(W'(1), W'(0));
        tick();
        op(W'(1), W'(1));
        repeat (2) tick();

        // Reseed with zero falls back to SEED
        seed_load = 1'b1;
        seed_data = '0;
        tick();
        seed_load = 1'b0;
        op(W'($urandom), W'($urandom));
        repeat (2) tick();

        // Reseed together with an accept: op uses old masks, LFSR takes new value
        seed_load = 1'b1;
        seed_data = $urandom | 32'h1;
        op(W'($urandom), W'($urandom));
        seed_load = 1'b0;
        tick();
        op(W'($urandom), W'($urandom));
        repeat (2) tick();

        // Asynchronous reset while shares are in flight
        op(W'($urandom), W'($urandom));
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        repeat (2) tick();
        op('1, '1);
        repeat (2) tick();

        // Random traffic with occasional reseeds
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.a_in     = W'($urandom);
            bus.b_in     = W'($urandom);
            seed_load    = ($urandom_range(0, 24) == 0);
            seed_data    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            tick();
        end
        bus.in_valid = 1'b0;
        seed_load    = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
